axil_rd_arbiter: RTL and testbench

//   Shares one AXI4-Lite read slave (e.g. boot ROM) between NUM_M AXI4-Lite read masters
//   (instruction fetch, data load). Handles the AR and R channels only.

---
 rtl/axil_rd_arbiter.sv | 162 ++++++++++++++++
 tb/tb_axil_rd_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_rd_arbiter.sv
// Shares one AXI4-Lite read slave (AR/R channels) between NUM_M read masters, one transaction in flight.
// Arbitration is fixed priority (lowest index wins) unless AXIL_ARB_RR_EN is defined, which selects round-robin.
module axil_rd_arbiter #(
  parameter int NUM_M  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_M*ADDR_W-1:0] s_araddr,
  input  logic [NUM_M*3-1:0]      s_arprot,
  input  logic [NUM_M-1:0]        s_arvalid,
  output logic [NUM_M-1:0]        s_arready,
  output logic [DATA_W-1:0]       s_rdata,
  output logic [1:0]              s_rresp,
  output logic [NUM_M-1:0]        s_rvalid,
  input  logic [NUM_M-1:0]        s_rready,
  output logic [ADDR_W-1:0]       m_araddr,
  output logic [2:0]              m_arprot,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  input  logic [DATA_W-1:0]       m_rdata,
  input  logic [1:0]              m_rresp,
  input  logic                    m_rvalid,
  output logic                    m_rready
);

  localparam int GW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [2:0]        arprot_q, arprot_d;
  logic              arvalid_q, arvalid_d;
  logic [NUM_M-1:0]  arready_q, arready_d;

  logic [GW-1:0]     win;
  logic [ADDR_W-1:0] win_addr;
  logic [2:0]        win_prot;
  logic              in_data;

`ifdef AXIL_ARB_RR_EN
  logic [GW-1:0] last_q, last_d;
  logic [GW-1:0] rr_idx;
  logic          rr_found;

  // Search starts just after the previous winner so every requester is served in turn.
  always_comb begin
    win      = '0;
    rr_idx   = '0;
    rr_found = 1'b0;
    for (int k = 1; k <= NUM_M; k++) begin
      rr_idx = GW'((int'(last_q) + k) % NUM_M);
      if (!rr_found && s_arvalid[rr_idx]) begin
        win      = rr_idx;
        rr_found = 1'b1;
      end
    end
  end
`else
  always_comb begin
    win = '0;
    for (int i = NUM_M - 1; i >= 0; i--) begin
      if (s_arvalid[i]) win = GW'(i);
    end
  end
`endif

  always_comb begin
    win_addr = '0;
    win_prot = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (win == GW'(i)) begin
        win_addr = s_araddr[i*ADDR_W +: ADDR_W];
        win_prot = s_arprot[i*3 +: 3];
      end
    end
  end

  assign in_data = (state_q == ST_DATA);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    araddr_d  = araddr_q;
    arprot_d  = arprot_q;
    arvalid_d = arvalid_q;
    arready_d = '0;
`ifdef AXIL_ARB_RR_EN
    last_d    = last_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|s_arvalid) begin
          state_d   = ST_ADDR;
          grant_d   = win;
          araddr_d  = win_addr;
          arprot_d  = win_prot;
          arvalid_d = 1'b1;
          arready_d = {{(NUM_M-1){1'b0}}, 1'b1} << win;
`ifdef AXIL_ARB_RR_EN
          last_d    = win;
`endif
        end
      end
      ST_ADDR: begin
        if (m_arready) begin
          arvalid_d = 1'b0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        // No re-arbitration on the completing beat; the next grant waits one IDLE cycle.
        if (m_rvalid && m_rready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      araddr_q  <= '0;
      arprot_q  <= '0;
      arvalid_q <= 1'b0;
      arready_q <= '0;
`ifdef AXIL_ARB_RR_EN
      last_q    <= GW'(NUM_M - 1);
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      araddr_q  <= araddr_d;
      arprot_q  <= arprot_d;
      arvalid_q <= arvalid_d;
      arready_q <= arready_d;
`ifdef AXIL_ARB_RR_EN
      last_q    <= last_d;
`endif
    end
  end

  assign m_araddr  = araddr_q;
  assign m_arprot  = arprot_q;
  assign m_arvalid = arvalid_q;
  assign s_arready = arready_q;

  assign s_rdata  = m_rdata;
  assign s_rresp  = m_rresp;
  assign m_rready = in_data && s_rready[grant_q];

  always_comb begin
    s_rvalid = '0;
    if (in_data) s_rvalid[grant_q] = m_rvalid;
  end

endmodule

// File: tb/tb_axil_rd_arbiter.sv
// Random multi-master read traffic against a transaction-level arbitration model with an AR/R scoreboard.
module tb_axil_rd_arbiter;

  localparam int NUM_M  = 2;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic                    clk;
  logic                    reset_n;
  logic [NUM_M*ADDR_W-1:0] s_araddr;
  logic [NUM_M*3-1:0]      s_arprot;
  logic [NUM_M-1:0]        s_arvalid;
  logic [NUM_M-1:0]        s_arready;
  logic [DATA_W-1:0]       s_rdata;
  logic [1:0]              s_rresp;
  logic [NUM_M-1:0]        s_rvalid;
  logic [NUM_M-1:0]        s_rready;
  logic [ADDR_W-1:0]       m_araddr;
  logic [2:0]              m_arprot;
  logic                    m_arvalid;
  logic                    m_arready;
  logic [DATA_W-1:0]       m_rdata;
  logic [1:0]              m_rresp;
  logic                    m_rvalid;
  logic                    m_rready;

  axil_rd_arbiter #(.NUM_M(NUM_M), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          m;
    logic [31:0] addr;
    logic [2:0]  prot;
    logic [31:0] data;
    logic [1:0]  resp;
  } txn_t;

  txn_t exp_ar[$];
  txn_t exp_r[$];

  int total = 0;
  int bad   = 0;

  // Reference view: 0 = no transaction, 1 = address offered to slave, 2 = waiting for read data.
  int          ph      = 0;
  int          g       = 0;
  int          last    = NUM_M - 1;
  logic        pulse   = 1'b0;
  logic        rst_chk = 1'b0;
  logic [31:0] cur_addr = '0;
  logic [2:0]  cur_prot = '0;

  logic [31:0] m_addr [NUM_M];
  logic [2:0]  m_prot [NUM_M];
  logic        req_en   = 1'b1;
  logic        burst    = 1'b1;
  logic        want_rst = 1'b0;
  logic        rst_done = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rd_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hDEADBEEF;
  endfunction

  function automatic logic [NUM_M-1:0] oh(input int i);
    logic [NUM_M-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int pick(input logic [NUM_M-1:0] req, input int lst);
`ifdef AXIL_ARB_RR_EN
    for (int k = 1; k <= NUM_M; k++) begin
      int c;
      c = (lst + k) % NUM_M;
      if (req[c]) return c;
    end
`else
    for (int i = 0; i < NUM_M; i++) if (req[i]) return i;
    if (lst < 0) return 0;
`endif
    return 0;
  endfunction

  // Transaction-level model: one read at a time, winner chosen from the pending set.
  initial begin
    forever begin
      @(posedge clk);
      pulse = 1'b0;
      if (!reset_n) begin
        ph = 0; last = NUM_M - 1; rst_chk = 1'b1;
        exp_ar.delete();
        exp_r.delete();
      end else if (ph == 0) begin
        if (s_arvalid != '0) begin
          txn_t t;
          g = pick(s_arvalid, last);
          last = g;
          cur_addr = m_addr[g];
          cur_prot = m_prot[g];
          t.m = g; t.addr = cur_addr; t.prot = cur_prot;
          t.data = rd_of(cur_addr); t.resp = cur_addr[3:2];
          exp_ar.push_back(t);
          exp_r.push_back(t);
          pulse = 1'b1;
          ph = 1;
        end
      end else if (ph == 1) begin
        if (m_arready) ph = 2;
      end else begin
        if (m_rvalid && s_rready[g]) ph = 0;
      end
    end
  end

  // Masters and slave responder; inputs change 1 time unit after the rising edge.
  initial begin
    logic [NUM_M-1:0] ar_hs;
    logic        mar_hs, mr_hs, sl_busy;
    logic [31:0] hs_addr, sl_addr;
    int          sl_cnt, rst_left;
    reset_n = 1'b0; s_arvalid = '0; s_araddr = '0; s_arprot = '0; s_rready = '0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0;
    for (int i = 0; i < NUM_M; i++) begin m_addr[i] = '0; m_prot[i] = '0; end
    sl_busy = 1'b0; sl_addr = '0; sl_cnt = 0; rst_left = 3;
    forever begin
      @(posedge clk);
      ar_hs   = s_arready & s_arvalid;
      mar_hs  = m_arvalid && m_arready;
      mr_hs   = m_rvalid && m_rready;
      hs_addr = m_araddr;
      #1;
      if (rst_left > 0 || (want_rst && ph == 2)) begin
        if (rst_left > 0) rst_left--;
        else begin want_rst = 1'b0; rst_done = 1'b1; end
        reset_n = 1'b0; s_arvalid = '0; m_arready = 1'b0; m_rvalid = 1'b0;
        sl_busy = 1'b0; burst = 1'b1;
      end else begin
        reset_n = 1'b1;
        for (int i = 0; i < NUM_M; i++) begin
          if (ar_hs[i]) s_arvalid[i] = 1'b0;
          else if (!s_arvalid[i] && req_en && (burst || $urandom_range(0, 1) == 1)) begin
            m_addr[i] = $urandom & 32'hFFFF_FFFC;
            m_prot[i] = 3'($urandom_range(0, 7));
            s_araddr[i*ADDR_W +: ADDR_W] = m_addr[i];
            s_arprot[i*3 +: 3] = m_prot[i];
            s_arvalid[i] = 1'b1;
          end
          s_rready[i] = ($urandom_range(0, 3) != 0);
        end
        burst = 1'b0;
        if (mr_hs) begin m_rvalid = 1'b0; sl_busy = 1'b0; end
        if (mar_hs) begin
          m_arready = 1'b0; sl_busy = 1'b1; sl_addr = hs_addr; sl_cnt = $urandom_range(0, 3);
        end else if (!sl_busy) m_arready = m_arvalid && ($urandom_range(0, 2) != 0);
        if (sl_busy && !m_rvalid) begin
          if (sl_cnt == 0) begin
            m_rvalid = 1'b1; m_rdata = rd_of(sl_addr); m_rresp = sl_addr[3:2];
          end else sl_cnt--;
        end
        if (!m_rvalid) begin m_rdata = $urandom; m_rresp = 2'($urandom_range(0, 3)); end
      end
    end
  end

  // Monitor: per-cycle output checks plus scoreboard pops on AR grant and R handshake.
  initial begin
    forever begin
      @(negedge clk);
      chk("s_rvalid", s_rvalid, (ph == 2 && m_rvalid) ? oh(g) : {NUM_M{1'b0}});
      chk("m_rready", m_rready, (ph == 2) ? s_rready[g] : 1'b0);
      chk("s_rdata_pass", s_rdata, m_rdata);
      chk("s_rresp_pass", s_rresp, m_rresp);
      chk("m_arvalid", m_arvalid, (ph == 1));
      chk("s_arready_pulse", s_arready, pulse ? oh(g) : {NUM_M{1'b0}});
      if (ph == 1) begin
        chk("m_araddr_hold", m_araddr, cur_addr);
        chk("m_arprot_hold", m_arprot, cur_prot);
      end
      if (rst_chk) begin
        chk("reset_m_araddr", m_araddr, 0);
        chk("reset_m_arprot", m_arprot, 0);
        rst_chk = 1'b0;
      end
      if (s_arready != '0) begin
        if (exp_ar.size() == 0) chk("ar_unexpected_grant", s_arready, 0);
        else begin
          txn_t t;
          t = exp_ar.pop_front();
          chk("ar_grant_master", s_arready, oh(t.m));
          chk("ar_grant_addr", m_araddr, t.addr);
          chk("ar_grant_prot", m_arprot, t.prot);
        end
      end
      if ((s_rvalid & s_rready) != '0) begin
        if (exp_r.size() == 0) chk("r_unexpected_beat", s_rvalid, 0);
        else begin
          txn_t t;
          t = exp_r.pop_front();
          chk("r_master", s_rvalid & s_rready, oh(t.m));
          chk("r_data", s_rdata, t.data);
          chk("r_resp", s_rresp, t.resp);
        end
      end
    end
  end

  initial begin
    repeat (1500) @(posedge clk);
    want_rst = 1'b1;
    for (int i = 0; i < 2000 && !rst_done; i++) @(posedge clk);
    chk("reset_in_data_reached", rst_done, 1);
    repeat (1500) @(posedge clk);
    req_en = 1'b0;
    for (int i = 0; i < 500 && !(s_arvalid == '0 && ph == 0); i++) @(posedge clk);
    repeat (3) @(posedge clk);
    chk("drain_idle", ph, 0);
    chk("drain_ar_queue", exp_ar.size(), 0);
    chk("drain_r_queue", exp_r.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
